// File: rtl/load_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_mem_unit
//  Purpose  : In-order load execution stage: FIFO, word read, extend, CDB.
//  Revision : 1.0
// ============================================================================
module load_mem_unit #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [31:0]      load_addr,
    input  logic [2:0]       load_type,
    input  logic [TAG_W-1:0] load_rob,
    input  logic             flush,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [31:0]      cdb_data,
    output logic [TAG_W-1:0] cdb_rob
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_CDB_WAIT = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    logic [31:0]      fifo_addr_q [DEPTH];
    logic [2:0]       fifo_type_q [DEPTH];
    logic [TAG_W-1:0] fifo_rob_q  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    state_t           state_q, state_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic [2:0]       cur_type_q, cur_type_d;
    logic [31:0]      cdb_data_q, cdb_data_d;
    logic [TAG_W-1:0] cdb_rob_q, cdb_rob_d;

    logic do_push, do_pop;

    function automatic logic type_is_mem(input logic [2:0] t);
        return (t == 3'b000) || (t == 3'b001) || (t == 3'b010) ||
               (t == 3'b100) || (t == 3'b101);
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] t,
                                            input logic [1:0] off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = w;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign load_ready = (count_q != FULL_CNT) && (state_q != S_DRAIN);
    assign do_push    = load_valid && load_ready && !flush;

    assign mem_req  = (state_q == S_MEM_WAIT);
    assign mem_addr = {cur_addr_q[31:2], 2'b00};
    assign cdb_req  = (state_q == S_CDB_WAIT);
    assign cdb_data = cdb_data_q;
    assign cdb_rob  = cdb_rob_q;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        cur_type_d = cur_type_q;
        cdb_data_d = cdb_data_q;
        cdb_rob_d  = cdb_rob_q;
        do_pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush && (count_q != '0)) begin
                    do_pop     = 1'b1;
                    cur_addr_d = fifo_addr_q[rd_ptr_q];
                    cur_type_d = fifo_type_q[rd_ptr_q];
                    cdb_rob_d  = fifo_rob_q[rd_ptr_q];
                    if (type_is_mem(fifo_type_q[rd_ptr_q])) begin
                        state_d = S_MEM_WAIT;
                    end else begin
                        cdb_data_d = 32'd0;
                        state_d    = S_CDB_WAIT;
                    end
                end
            end
            S_MEM_WAIT: begin
                // An ack coinciding with flush already retires the outstanding read.
                if (mem_ack) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        cdb_data_d = extract(cur_type_q, cur_addr_q[1:0], mem_rdata);
                        state_d    = S_CDB_WAIT;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_CDB_WAIT: begin
                if (flush || cdb_grant) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_addr_q <= 32'd0;
            cur_type_q <= 3'd0;
            cdb_data_q <= 32'd0;
            cdb_rob_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            cur_type_q <= cur_type_d;
            cdb_data_q <= cdb_data_d;
            cdb_rob_q  <= cdb_rob_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (do_push && !do_pop)      count_q <= count_q + 1'b1;
                else if (!do_push && do_pop) count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            fifo_addr_q[wr_ptr_q] <= load_addr;
            fifo_type_q[wr_ptr_q] <= load_type;
            fifo_rob_q[wr_ptr_q]  <= load_rob;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_mem_unit
//  Purpose  : Directed self-checking bench for load_mem_unit.
//  Revision : 1.0
// ============================================================================
module tb_load_mem_unit;

    logic        clock = 1'b0;
    logic        reset, load_valid, load_ready, flush;
    logic [31:0] load_addr, mem_addr, mem_rdata, cdb_data;
    logic [2:0]  load_type;
    logic [5:0]  load_rob, cdb_rob;
    logic        mem_req, mem_ack, cdb_req, cdb_grant;

    int total = 0;
    int bad   = 0;

    load_mem_unit #(.DEPTH(2), .TAG_W(6)) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_type(load_type), .load_rob(load_rob),
        .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cdb_data(cdb_data), .cdb_rob(cdb_rob)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [2:0] t, input logic [5:0] r);
        load_valid = 1'b1;
        load_addr  = a;
        load_type  = t;
        load_rob   = r;
        step();
        load_valid = 1'b0;
    endtask

    // Completes the load currently in MEM_WAIT and leaves the unit ready to pop again.
    task automatic serve(input string tag, input logic [31:0] exp_maddr, input logic [31:0] rd,
                         input logic [31:0] exp_data, input logic [5:0] exp_rob);
        check({tag, ".mem_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, ".mem_addr"}, mem_addr, exp_maddr);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_A5A5;
        check({tag, ".cdb_req"}, {31'd0, cdb_req}, 32'd1);
        check({tag, ".cdb_data"}, cdb_data, exp_data);
        check({tag, ".cdb_rob"}, {26'd0, cdb_rob}, {26'd0, exp_rob});
        check({tag, ".mem_req_off"}, {31'd0, mem_req}, 32'd0);
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
        check({tag, ".cdb_drop"}, {31'd0, cdb_req}, 32'd0);
        step();
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_type = '0; load_rob = '0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0; cdb_grant = 1'b0;
        step(); step();
        reset = 1'b0;

        check("rst.load_ready", {31'd0, load_ready}, 32'd1);
        check("rst.mem_req",    {31'd0, mem_req},    32'd0);
        check("rst.mem_addr",   mem_addr,            32'd0);
        check("rst.cdb_req",    {31'd0, cdb_req},    32'd0);
        check("rst.cdb_data",   cdb_data,            32'd0);
        check("rst.cdb_rob",    {26'd0, cdb_rob},    32'd0);

        // LW with ack in first request cycle
        push(32'h100, 3'b010, 6'd5);
        check("lw.mem_req_n", {31'd0, mem_req}, 32'd0);
        step();
        serve("lw", 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 6'd5);

        // Byte/half extraction from one word
        push(32'h203, 3'b000, 6'd1); step();
        serve("lb",  32'h200, 32'h80F17F01, 32'hFFFFFF80, 6'd1);
        push(32'h203, 3'b100, 6'd2); step();
        serve("lbu", 32'h200, 32'h80F17F01, 32'h00000080, 6'd2);
        push(32'h202, 3'b001, 6'd3); step();
        serve("lh",  32'h200, 32'h80F17F01, 32'hFFFF80F1, 6'd3);
        push(32'h200, 3'b101, 6'd4); step();
        serve("lhu", 32'h200, 32'h80F17F01, 32'h00007F01, 6'd4);
        push(32'h201, 3'b100, 6'd6); step();
        serve("lbu1", 32'h200, 32'h80F17F01, 32'h0000007F, 6'd6);

        // Reserved type skips memory and broadcasts zero; stray ack ignored
        push(32'h800, 3'b011, 6'd20);
        step();
        check("rsv.cdb_req",  {31'd0, cdb_req}, 32'd1);
        check("rsv.cdb_data", cdb_data,         32'd0);
        check("rsv.cdb_rob",  {26'd0, cdb_rob}, 32'd20);
        check("rsv.mem_req",  {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        check("rsv.hold",     {31'd0, cdb_req}, 32'd1);
        check("rsv.hold_dat", cdb_data,         32'd0);
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
        check("rsv.drop",     {31'd0, cdb_req}, 32'd0);

        // Backpressure: three loads, ack withheld
        push(32'h300, 3'b010, 6'd7);
        check("bp.ready1", {31'd0, load_ready}, 32'd1);
        push(32'h304, 3'b010, 6'd8);
        check("bp.ready2", {31'd0, load_ready}, 32'd1);
        push(32'h308, 3'b010, 6'd9);
        check("bp.full", {31'd0, load_ready}, 32'd0);
        step(); step();
        check("bp.full_hold", {31'd0, load_ready}, 32'd0);
        serve("bp.a", 32'h300, 32'h11111111, 32'h11111111, 6'd7);
        check("bp.ready_back", {31'd0, load_ready}, 32'd1);
        serve("bp.b", 32'h304, 32'h22222222, 32'h22222222, 6'd8);
        serve("bp.c", 32'h308, 32'h33333333, 32'h33333333, 6'd9);
        check("bp.idle", {31'd0, mem_req}, 32'd0);

        // CDB stall with a second load queued behind
        push(32'h400, 3'b010, 6'd10);
        step();
        check("st.mem_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        load_valid = 1'b1; load_addr = 32'h500; load_type = 3'b010; load_rob = 6'd11;
        step();
        mem_ack = 1'b0; load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("st.cdb_req",  {31'd0, cdb_req}, 32'd1);
            check("st.cdb_data", cdb_data,         32'h12345678);
            check("st.cdb_rob",  {26'd0, cdb_rob}, 32'd10);
            check("st.no_mem",   {31'd0, mem_req}, 32'd0);
            step();
        end
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
        check("st.drop", {31'd0, cdb_req}, 32'd0);
        step();
        serve("st.next", 32'h500, 32'hCAFEF00D, 32'hCAFEF00D, 6'd11);

        // Flush in MEM_WAIT with one load queued
        push(32'h600, 3'b010, 6'd12);
        push(32'h700, 3'b010, 6'd13);
        check("fl.mem_req", {31'd0, mem_req}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl.req_off", {31'd0, mem_req},    32'd0);
        check("fl.drain",   {31'd0, load_ready}, 32'd0);
        check("fl.no_cdb",  {31'd0, cdb_req},    32'd0);
        step(); step();
        check("fl.drain2",  {31'd0, load_ready}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        step();
        mem_ack = 1'b0;
        check("fl.ready",   {31'd0, load_ready}, 32'd1);
        check("fl.no_cdb2", {31'd0, cdb_req},    32'd0);
        step(); step();
        check("fl.empty_mem", {31'd0, mem_req}, 32'd0);
        check("fl.empty_cdb", {31'd0, cdb_req}, 32'd0);

        // Reset during CDB_WAIT
        push(32'h900, 3'b010, 6'd14);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        step();
        mem_ack = 1'b0;
        check("rc.cdb_req", {31'd0, cdb_req}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rc.cdb_off",  {31'd0, cdb_req},    32'd0);
        check("rc.ready",    {31'd0, load_ready}, 32'd1);
        check("rc.cdb_data", cdb_data,            32'd0);
        check("rc.cdb_rob",  {26'd0, cdb_rob},    32'd0);
        step(); step();
        check("rc.quiet_cdb", {31'd0, cdb_req}, 32'd0);
        check("rc.quiet_mem", {31'd0, mem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
